// File: rtl/mult4u_redundant_sched_if.sv
// Bundle of requester, shared-multiplier and response signals for mult4u_redundant_sched.
// The slave side belongs to the scheduler; the master side belongs to its surroundings.
interface mult4u_redundant_sched_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [7:0]       req_a;
  logic [7:0]       req_b;
  logic [3:0]       mult_a;
  logic [3:0]       mult_b;
  logic [7:0]       mult_p;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [7:0]       resp_prod;
  logic             resp_err;
  logic [CNT_W-1:0] fault_cnt;

  modport slave (
    input  req_valid, req_a, req_b, mult_p, resp_ready,
    output req_ready, mult_a, mult_b, resp_valid, resp_id, resp_prod, resp_err, fault_cnt
  );

  modport master (
    output req_valid, req_a, req_b, mult_p, resp_ready,
    input  req_ready, mult_a, mult_b, resp_valid, resp_id, resp_prod, resp_err, fault_cnt
  );
endinterface

// File: rtl/mult4u_redundant_sched.sv
// Round-robin scheduler sharing one 4x4 multiplier between two requesters; every product
// is computed as A*B and again as B*A, with mismatches retried and counted.
module mult4u_redundant_sched #(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input logic                      clk,
  input logic                      rst,
  mult4u_redundant_sched_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_CMP, S_RESP} state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             r_id;
  logic [3:0]       r_opa;
  logic [3:0]       r_opb;
  logic [7:0]       r_p1;
  logic [7:0]       r_p2;
  logic [2:0]       r_retry;
  logic             r_err;
  logic [CNT_W-1:0] r_fault_cnt;

  logic       w_gnt_vld;
  logic       w_gnt_id;
  logic       w_mismatch;
  logic       w_can_retry;
  logic [1:0] w_req_ready;
  logic [3:0] w_mult_a;
  logic [3:0] w_mult_b;
  logic       w_resp_valid;

  // The pointer requester wins a tie; otherwise whichever one is valid
  assign w_gnt_vld   = |bus.req_valid;
  assign w_gnt_id    = bus.req_valid[r_ptr] ? r_ptr : ~r_ptr;
  assign w_mismatch  = (r_p1 != r_p2);
  assign w_can_retry = (r_retry < MAX_R);

  // Next-state logic, accept strobe and multiplier operand steering
  always_comb begin
    w_next      = r_state;
    w_req_ready = 2'b00;
    w_mult_a    = 4'd0;
    w_mult_b    = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld && !rst) begin
          w_req_ready = w_gnt_id ? 2'b10 : 2'b01;
          w_next      = S_P1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_P1: begin
        w_mult_a = r_opa;
        w_mult_b = r_opb;
        w_next   = S_P2;
      end
      S_P2: begin
        w_mult_a = r_opb;
        w_mult_b = r_opa;
        w_next   = S_CMP;
      end
      S_CMP: begin
        if (w_mismatch && w_can_retry) begin
          w_next = S_P1;
        end else begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus operand, product, retry and fault bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_opa       <= 4'd0;
      r_opb       <= 4'd0;
      r_p1        <= 8'd0;
      r_p2        <= 8'd0;
      r_retry     <= 3'd0;
      r_err       <= 1'b0;
      r_fault_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_opa   <= w_gnt_id ? bus.req_a[7:4] : bus.req_a[3:0];
            r_opb   <= w_gnt_id ? bus.req_b[7:4] : bus.req_b[3:0];
            r_id    <= w_gnt_id;
            r_retry <= 3'd0;
            r_err   <= 1'b0;
          end
        end
        S_P1: r_p1 <= bus.mult_p;
        S_P2: r_p2 <= bus.mult_p;
        S_CMP: begin
          // err is only set once the retry budget is spent without agreement
          r_err <= w_mismatch && !w_can_retry;
          if (w_mismatch) begin
            if (r_fault_cnt != {CNT_W{1'b1}}) begin
              r_fault_cnt <= r_fault_cnt + CNT_W'(1);
            end
            if (w_can_retry) begin
              r_retry <= r_retry + 3'd1;
            end
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_ptr <= ~r_id;
          end
        end
        default: r_retry <= 3'd0;
      endcase
    end
  end

  assign w_resp_valid  = (r_state == S_RESP);
  assign bus.req_ready = w_req_ready;
  assign bus.mult_a    = w_mult_a;
  assign bus.mult_b    = w_mult_b;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_id   = w_resp_valid & r_id;
  assign bus.resp_prod = w_resp_valid ? r_p2 : 8'd0;
  assign bus.resp_err  = w_resp_valid & r_err;
  assign bus.fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_mult4u_redundant_sched.sv
// Randomized bench for mult4u_redundant_sched: a behavioural model predicts grant order,
// latency, product, error flag and fault count; the multiplier is modelled with fault injection.
module tb_mult4u_redundant_sched;

  localparam int MAXR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult4u_redundant_sched_if #(.CNT_W(8)) bus ();

  mult4u_redundant_sched #(.MAX_RETRY(MAXR), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks    = 0;
  int         failures  = 0;
  int         mode_r    = 0;
  logic       used      = 1'b0;
  logic [3:0] cur_a     = 4'd0;
  logic [3:0] cur_b     = 4'd0;
  logic       last_id;
  int         exp_fault;
  logic       corrupt_now;

  // Fault injection flips bit 0 on the swapped (B*A) pass of the current operation
  assign corrupt_now = (cur_a != cur_b) && (bus.mult_a == cur_b) && (bus.mult_b == cur_a) &&
                       ((mode_r == 2) || (mode_r == 1 && !used));
  assign bus.mult_p  = (8'(bus.mult_a) * 8'(bus.mult_b)) ^ {7'd0, corrupt_now};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] vmask, input logic [3:0] a0, input logic [3:0] b0,
                       input logic [3:0] a1, input logic [3:0] b1, input int mode, input int delay);
    logic       pref;
    logic       gid;
    logic [3:0] a;
    logic [3:0] b;
    int         mism;
    int         retries;
    int         exp_lat;
    int         lat;
    logic       exp_err;
    logic [7:0] exp_prod;
    pref     = ~last_id;
    gid      = vmask[pref] ? pref : ~pref;
    a        = gid ? a1 : a0;
    b        = gid ? b1 : b0;
    mism     = (mode == 0) ? 0 : ((mode == 1) ? 1 : MAXR + 1);
    retries  = (mism > MAXR) ? MAXR : mism;
    exp_lat  = 4 + 3 * retries;
    exp_err  = (mism > MAXR);
    exp_prod = (8'(a) * 8'(b)) ^ ((mode == 2) ? 8'h01 : 8'h00);
    exp_fault = (exp_fault + mism > 255) ? 255 : exp_fault + mism;
    cur_a  = a;
    cur_b  = b;
    mode_r = mode;
    used   = 1'b0;
    bus.req_a      = {a1, a0};
    bus.req_b      = {b1, b0};
    bus.req_valid  = vmask;
    bus.resp_ready = (delay == 0);
    #1;
    check_eq("req_ready", 32'(bus.req_ready), gid ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.req_a     = 8'($urandom);
    bus.req_b     = 8'($urandom);
    #1;
    check_eq("p1_ops", 32'({bus.mult_a, bus.mult_b}), 32'({a, b}));
    @(posedge clk); #1;
    check_eq("p2_ops", 32'({bus.mult_a, bus.mult_b}), 32'({b, a}));
    @(posedge clk); #1;
    used = 1'b1;
    lat  = 3;
    while (!bus.resp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("resp_id", 32'(bus.resp_id), 32'(gid));
    check_eq("resp_prod", 32'(bus.resp_prod), 32'(exp_prod));
    check_eq("resp_err", 32'(bus.resp_err), 32'(exp_err));
    check_eq("fault_cnt", 32'(bus.fault_cnt), 32'(exp_fault));
    for (int d = 0; d < delay; d++) begin
      bus.req_valid = 2'b11;
      #1;
      check_eq("stall", 32'({bus.resp_valid, bus.resp_id, bus.resp_prod, bus.resp_err, bus.req_ready}),
               32'({1'b1, gid, exp_prod, exp_err, 2'b00}));
      @(posedge clk); #1;
    end
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b1;
    #1;
    if (delay > 0) check_eq("hold_end", 32'(bus.resp_valid), 32'd1);
    @(posedge clk); #1;
    check_eq("resp_done", 32'(bus.resp_valid), 32'd0);
    last_id = gid;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst            = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_a      = 8'd0;
    bus.req_b      = 8'd0;
    bus.resp_ready = 1'b1;
    last_id        = 1'b1;
    exp_fault      = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", 32'({bus.req_ready, bus.mult_a, bus.mult_b, bus.resp_valid, bus.resp_id,
                                bus.resp_prod, bus.resp_err, bus.fault_cnt}), 32'd0);
    rst = 1'b0;

    // Both requesters valid at reset release: requester 0 first, then 1
    do_op(2'b11, 4'd15, 4'd15, 4'd7, 4'd9, 0, 0);
    do_op(2'b10, 4'd15, 4'd15, 4'd7, 4'd9, 0, 0);
    do_op(2'b01, 4'd3, 4'd5, 4'd0, 4'd0, 0, 0);
    // Single corrupted B*A pass, then persistent corruption
    do_op(2'b01, 4'd6, 4'd4, 4'd0, 4'd0, 1, 0);
    do_op(2'b01, 4'd9, 4'd2, 4'd0, 4'd0, 2, 0);
    do_op(2'b10, 4'd0, 4'd0, 4'd13, 4'd11, 0, 5);

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            0, int'($urandom_range(0, 3)));
    end

    // Reset during P2 aborts the operation silently
    mode_r        = 0;
    bus.req_a     = 8'h75;
    bus.req_b     = 8'h57;
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_outs", 32'({bus.req_ready, bus.mult_a, bus.mult_b, bus.resp_valid, bus.resp_id,
                                bus.resp_prod, bus.resp_err, bus.fault_cnt}), 32'd0);
    rst       = 1'b0;
    exp_fault = 0;
    last_id   = 1'b1;
    seen      = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    check_eq("no_abort_resp", 32'(seen), 32'd0);
    do_op(2'b11, 4'd12, 4'd10, 4'd1, 4'd2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult4u_redundant_sched.md
Name: mult4u_redundant_sched

Overview:
Sequencer and arbiter that shares one combinational unsigned 4x4 multiplier instance between two requesters. It uses temporal redundancy to detect faults. Each operation runs twice, first as A*B and then with operands swapped as B*A, and the two products are compared. On a mismatch the pair is retried up to MAX_RETRY times; the response then carries a product and an error flag. The block sits between requester logic and any mult4u_* core in the library.

Parameters:
MAX_RETRY, 2, extra attempt pairs after the first mismatch (total attempts = 1+MAX_RETRY); legal range 0..7
CNT_W, 8, width of the saturating mismatch counter

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  2  per-requester request valid (bit i = requester i)
req_ready  output  2  per-requester accept; at most one bit high per cycle
req_a  input  8  operand A; [3:0] requester 0, [7:4] requester 1
req_b  input  8  operand B; same packing as req_a
mult_a  output  4  operand A driven to the shared multiplier
mult_b  output  4  operand B driven to the shared multiplier
mult_p  input  8  product returned by the shared multiplier (combinational)
resp_valid  output  1  response valid
resp_ready  input  1  response accept
resp_id  output  1  requester that owns the response
resp_prod  output  8  product (value from the last B*A pass)
resp_err  output  1  1 = retries exhausted without agreement
fault_cnt  output  CNT_W  saturating count of mismatches since reset

Behaviour:
- Reset (sync, active-high) puts every output at 0 and sets state=IDLE, the round-robin pointer to requester 0, retry=0 and fault_cnt=0. Reset mid-operation aborts that operation with no response.
- States: IDLE, P1, P2, CMP, RESP.
- IDLE:
  - Grant goes to the pointer requester if its valid is high, otherwise to the other requester if its valid is high.
  - req_ready[grant] is asserted combinationally in this cycle; the handshake occurs here.
  - Operands latched into opA/opB, grant id latched, retry cleared, next state P1.
  - With no valid request, stay in IDLE; req_ready=0.
- P1: mult_a=opA, mult_b=opB; p1 <= mult_p at the clock edge; next state P2.
- P2: mult_a=opB, mult_b=opA; p2 <= mult_p; next state CMP.
- In all states other than P1 and P2, mult_a=mult_b=0.
- CMP:
  - p1==p2 -> RESP with err=0.
  - Otherwise fault_cnt increments (saturating at all-ones, no wrap).
  - If retry<MAX_RETRY: retry++, next state P1.
  - Else: RESP with err=1.
- RESP:
  - resp_valid=1; resp_id, resp_prod=p2 and resp_err stay stable until resp_ready is high.
  - On the handshake: pointer <= ~resp_id, next state IDLE.
  - No new request is accepted in this cycle.
- Latency:
  - Accept at cycle T gives resp_valid at T+4 with no mismatch.
  - Each retry adds 3 cycles.
  - Worst case T+4+3*MAX_RETRY.
- Throughput: one operation in flight; the minimum interval between accepts is 5 cycles.
- Simultaneous requests after reset: requester 0 first, then requester 1. Fairness strictly alternates while both stay valid.
- req_a/req_b are sampled only on the accept cycle. Later changes have no effect.
- Arithmetic: unsigned; 4b x 4b -> 8b with no truncation.

Test Plan:
- req0 valid, A=3, B=5, resp_ready=1 -> req_ready[0] high at T; mult_a/mult_b = 3/5 at T+1 and 5/3 at T+2; resp_valid at T+4 with resp_prod=15, resp_id=0, resp_err=0; fault_cnt=0.
- Both valid at reset release (req0 A=15 B=15; req1 A=7 B=9) -> req0 accepted first, resp_prod=225. req1 accepted in the IDLE cycle after the RESP handshake, resp_prod=63, resp_id=1.
- Bench XORs mult_p with 0x01 during the first P2 only (A=6, B=4) -> retry; resp_valid at T+7 with resp_prod=24, resp_err=0, fault_cnt=1.
- Persistent corruption in every P2, MAX_RETRY=2 -> resp_valid at T+10, resp_err=1, fault_cnt=3.
- resp_ready held low for 5 cycles in RESP -> resp_valid and the response fields stay stable; req_ready stays 0 throughout; completion follows once resp_ready=1.
- rst asserted during P2 -> next cycle all outputs are 0, state is IDLE, no response ever appears for the aborted request; a new request then completes normally.
